// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART serialiser and its baud-tick helper.
//   state_e        - transmitter FSM state encoding
//   LINE_MARK/SPACE - serial line levels (idle line is mark)
//   DEF_DATA_BITS  - default data bits per frame
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   localparam logic LINE_MARK  = 1'b1;
   localparam logic LINE_SPACE = 1'b0;

   localparam int unsigned DEF_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter shared by the UART transmitter and receiver.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load       - capture div and restart the count at 0
//   en         - advance the count (ignored while load is high)
//   div        - bit period minus one, in clk cycles
//   tick       - high on the last cycle of a bit period (bcnt == div_q)
//   tick_next  - high when the following cycle will be a tick cycle, assuming
//                the counter keeps running; lets the owner register
//                last-cycle pulses one cycle early
module uart_baud_tick #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick,
   output logic             tick_next
);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] bcnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         bcnt_q <= '0;
      end else if (load) begin
         div_q  <= div;
         bcnt_q <= '0;
      end else if (en) begin
         bcnt_q <= tick ? '0 : bcnt_q + DIV_W'(1);
      end
   end

   assign tick = (bcnt_q == div_q);
   // After a wrap the next count is 0, which only ticks for a one-cycle period.
   assign tick_next = tick ? (div_q == '0) : ((bcnt_q + DIV_W'(1)) == div_q);

endmodule

// File: rtl/uart_tx_ser.sv
// uart_tx_ser: parallel-to-serial UART transmitter.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// Optional parity is built when UART_TX_PARITY_EN is defined (adds parity_odd input).
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   baud_div    - bit period minus one (sampled at accept)
//   stop2       - 0: one stop bit, 1: two stop bits (sampled at accept)
//   parity_odd  - odd parity select (only with UART_TX_PARITY_EN, sampled at accept)
//   tx_data     - byte to send; tx_valid/tx_ready handshake
//   txsd        - registered serial output to the downstream delay stage
//   busy        - frame in progress
//   tx_done     - one-cycle pulse on the final cycle of the last stop bit
module uart_tx_ser
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = DEF_DATA_BITS,
   parameter int unsigned DIV_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 stop2,
`ifdef UART_TX_PARITY_EN
   input  logic                 parity_odd,
`endif
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txsd,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   state_e                 state_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic [IDX_W-1:0]       idx_q;
   logic                   stop2_q;
   logic                   stop_cnt_q;
   logic                   txsd_q;
   logic                   tx_ready_q;
   logic                   busy_q;
   logic                   tx_done_q;
`ifdef UART_TX_PARITY_EN
   logic                   parity_q;
`endif

   logic accept;
   logic tick;
   logic tick_next;

   assign accept = tx_valid & tx_ready_q;

   uart_baud_tick #(
      .DIV_W (DIV_W)
   ) u_baud_tick (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .en        (busy_q),
      .div       (baud_div),
      .tick      (tick),
      .tick_next (tick_next)
   );

   // tx_done is registered, so it is set one cycle ahead using tick_next.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         idx_q      <= '0;
         stop2_q    <= 1'b0;
         stop_cnt_q <= 1'b0;
         txsd_q     <= LINE_MARK;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         tx_done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q    <= ST_START;
                  txsd_q     <= LINE_SPACE;
                  shift_q    <= tx_data;
                  stop2_q    <= stop2;
                  idx_q      <= '0;
                  stop_cnt_q <= 1'b0;
                  tx_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                  parity_q   <= (^tx_data) ^ parity_odd;
`endif
               end
            end
            ST_START: begin
               if (tick) begin
                  state_q <= ST_DATA;
                  txsd_q  <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state_q   <= ST_PARITY;
                     txsd_q    <= parity_q;
`else
                     state_q   <= ST_STOP;
                     txsd_q    <= LINE_MARK;
                     tx_done_q <= tick_next & ~stop2_q;
`endif
                  end else begin
                     txsd_q  <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     idx_q   <= idx_q + IDX_W'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  state_q   <= ST_STOP;
                  txsd_q    <= LINE_MARK;
                  tx_done_q <= tick_next & ~stop2_q;
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (stop_cnt_q == stop2_q) begin
                     state_q    <= ST_IDLE;
                     tx_ready_q <= 1'b1;
                     busy_q     <= 1'b0;
                  end else begin
                     stop_cnt_q <= 1'b1;
                     tx_done_q  <= tick_next;
                  end
               end else begin
                  tx_done_q <= tick_next & (stop_cnt_q == stop2_q);
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               txsd_q     <= LINE_MARK;
               tx_ready_q <= 1'b1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign txsd     = txsd_q;
   assign tx_ready = tx_ready_q;
   assign busy     = busy_q;
   assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ser.sv
// tb_uart_tx_ser: directed self-checking bench for uart_tx_ser.
// Builds with or without UART_TX_PARITY_EN; expected frames adapt to the build.
module tb_uart_tx_ser;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned DIV_W     = 16;
`ifdef UART_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif

   logic                 clk;
   logic                 rst;
   logic [DIV_W-1:0]     baud_div;
   logic                 stop2;
   logic                 parity_odd;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 txsd;
   logic                 busy;
   logic                 tx_done;

   int checks = 0;
   int errors = 0;

   uart_tx_ser #(
      .DATA_BITS (DATA_BITS),
      .DIV_W     (DIV_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_div   (baud_div),
      .stop2      (stop2),
`ifdef UART_TX_PARITY_EN
      .parity_odd (parity_odd),
`endif
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .txsd       (txsd),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line level for bit slot idx of a frame.
   function automatic logic exp_bit(input int idx, input logic [7:0] d, input logic podd);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (PBITS == 1 && idx == 9) return (^d) ^ podd;
      return 1'b1;
   endfunction

   // Called at a negedge with the DUT idle; accept happens on the next posedge.
   task automatic start_frame(input logic [7:0] d, input int div, input logic s2,
                              input logic podd);
      tx_data    = d;
      baud_div   = DIV_W'(div);
      stop2      = s2;
      parity_odd = podd;
      tx_valid   = 1'b1;
      chk("accept_ready", {31'b0, tx_ready}, 32'd1);
   endtask

   // Checks every cycle of one frame; poke_k injects a spurious request mid-frame.
   task automatic check_frame(input string tag, input logic [7:0] d, input int div,
                              input logic s2, input logic podd, input bit drop,
                              input int poke_k);
      int per = div + 1;
      int len = (10 + PBITS + int'(s2)) * per;
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         chk($sformatf("%s_txsd_c%0d", tag, k), {31'b0, txsd},
             {31'b0, exp_bit((k - 1) / per, d, podd)});
         chk($sformatf("%s_done_c%0d", tag, k), {31'b0, tx_done}, {31'b0, k == len});
         chk($sformatf("%s_busy_c%0d", tag, k), {31'b0, busy}, 32'd1);
         chk($sformatf("%s_ready_c%0d", tag, k), {31'b0, tx_ready}, 32'd0);
         if (k == 1 && drop) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
         end
         if (k == poke_k) begin
            tx_valid = 1'b1;
            tx_data  = 8'hFF;
            baud_div = DIV_W'(7);
            stop2    = ~stop2;
         end
         if (k == poke_k + 1) tx_valid = 1'b0;
      end
   endtask

   task automatic idle_check(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("%s_ready_%0d", tag, i), {31'b0, tx_ready}, 32'd1);
         chk($sformatf("%s_busy_%0d", tag, i), {31'b0, busy}, 32'd0);
         chk($sformatf("%s_txsd_%0d", tag, i), {31'b0, txsd}, 32'd1);
         chk($sformatf("%s_done_%0d", tag, i), {31'b0, tx_done}, 32'd0);
      end
   endtask

   initial begin
      rst        = 1'b1;
      tx_valid   = 1'b0;
      tx_data    = '0;
      baud_div   = '0;
      stop2      = 1'b0;
      parity_odd = 1'b0;

      // Reset held for three cycles.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_txsd", {31'b0, txsd}, 32'd1);
      chk("rst_ready", {31'b0, tx_ready}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, tx_done}, 32'd0);
      rst = 1'b0;
      idle_check("idle", 2);

      // Basic frame 0x55, 4 cycles per bit.
      start_frame(8'h55, 3, 1'b0, 1'b0);
      check_frame("f55", 8'h55, 3, 1'b0, 1'b0, 1'b1, -1);
      idle_check("post55", 1);

      // Back-to-back at one cycle per bit with tx_valid held high.
      start_frame(8'hA3, 0, 1'b0, 1'b0);
      check_frame("fA3", 8'hA3, 0, 1'b0, 1'b0, 1'b0, -1);
      tx_data = 8'h0F;
      idle_check("gap", 1);
      check_frame("f0F", 8'h0F, 0, 1'b0, 1'b0, 1'b1, -1);
      idle_check("post0F", 2);

      // Two stop bits (plus even parity when built in).
      start_frame(8'h07, 1, 1'b1, 1'b0);
      check_frame("f07", 8'h07, 1, 1'b1, 1'b0, 1'b1, -1);
      idle_check("post07", 1);
`ifdef UART_TX_PARITY_EN
      start_frame(8'h07, 1, 1'b1, 1'b1);
      check_frame("f07odd", 8'h07, 1, 1'b1, 1'b1, 1'b1, -1);
      idle_check("post07odd", 1);
`endif

      // Reset during data bit 3 (cycles 17..20 of a 4-cycle-per-bit frame).
      start_frame(8'h00, 3, 1'b0, 1'b0);
      repeat (18) @(negedge clk);
      chk("pre_rst_txsd", {31'b0, txsd}, 32'd0);
      chk("pre_rst_busy", {31'b0, busy}, 32'd1);
      tx_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      chk("mid_rst_txsd", {31'b0, txsd}, 32'd1);
      chk("mid_rst_ready", {31'b0, tx_ready}, 32'd1);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_done", {31'b0, tx_done}, 32'd0);
      rst = 1'b0;
      idle_check("after_rst", 45);
      start_frame(8'hC6, 2, 1'b0, 1'b0);
      check_frame("fC6", 8'hC6, 2, 1'b0, 1'b0, 1'b1, -1);
      idle_check("postC6", 1);

      // Request pulsed mid-frame with new settings must be ignored.
      start_frame(8'h3C, 1, 1'b0, 1'b0);
      check_frame("f3C", 8'h3C, 1, 1'b0, 1'b0, 1'b1, 5);
      idle_check("no_ff", 25);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
